pps_phase_meter: RTL and testbench

Measures the time offset between the GPS 1PPS and the locally divided 1PPS, counted in CLK_SYS cycles. Each second it produces one signed phase-error sample for the GPSDO control loop that steers the 10 MHz oscillator. It also reports missing or unpaired pulses and loss of the GPS 1PPS.

---
 rtl/gpsdo_pkg.sv | 13 +
 rtl/pps_sync_edge.sv | 31 +++
 rtl/pps_phase_meter.sv | 203 ++++++++++++++++++++
 tb/tb_pps_phase_meter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpsdo_pkg.sv
// Shared GPSDO definitions: phase-meter FSM states and default clock/counter sizing.
package gpsdo_pkg;

    localparam int DEF_CLK_HZ = 100_000_000;
    localparam int DEF_CNT_W  = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_L = 2'd1,
        WAIT_G = 2'd2
    } meter_state_t;

endpackage

// File: rtl/pps_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Input-to-pulse latency is a fixed 3 cycles.
module pps_sync_edge (
    input  logic CLK_SYS,
    input  logic CLK_RST,
    input  logic din,
    output logic edge_p
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_edge;

    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_edge <= r_sync & ~r_prev;
        end
    end

    assign edge_p = r_edge;

endmodule

// File: rtl/pps_phase_meter.sv
// GPS vs local 1PPS phase meter: signed offset in CLK_SYS cycles, timeout and GPS-loss reporting.
// Optional running average of phase_err is built when PPS_PHASE_AVG_EN is defined.
module pps_phase_meter
    import gpsdo_pkg::*;
#(
    parameter int CLK_HZ   = DEF_CLK_HZ,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int MAX_CNT  = CLK_HZ / 2,
    parameter int LOST_CNT = CLK_HZ * 3 / 2,
    parameter int AVG_LOG2 = 4
) (
    input  logic             CLK_SYS,
    input  logic             CLK_RST,
    input  logic             _1PPS_GPS,
    input  logic             _1PPS_Local,
    output logic [CNT_W-1:0] phase_err,
    output logic             phase_valid,
    output logic             meas_timeout,
    output logic             gps_lost,
    output logic [CNT_W-1:0] phase_avg,
    output logic             avg_valid
);

    localparam int LOST_W = $clog2(LOST_CNT + 1);

    logic w_g_e;
    logic w_l_e;

    pps_sync_edge u_sync_gps (
        .CLK_SYS (CLK_SYS),
        .CLK_RST (CLK_RST),
        .din     (_1PPS_GPS),
        .edge_p  (w_g_e)
    );

    pps_sync_edge u_sync_local (
        .CLK_SYS (CLK_SYS),
        .CLK_RST (CLK_RST),
        .din     (_1PPS_Local),
        .edge_p  (w_l_e)
    );

    meter_state_t     r_state;
    meter_state_t     w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] r_phase_err;
    logic [CNT_W-1:0] w_err_next;
    logic             r_phase_valid;
    logic             w_valid_next;
    logic             r_meas_timeout;
    logic             w_timeout_next;

    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_phase_err    <= '0;
            r_phase_valid  <= 1'b0;
            r_meas_timeout <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_phase_err    <= w_err_next;
            r_phase_valid  <= w_valid_next;
            r_meas_timeout <= w_timeout_next;
        end
    end

    // A pairing edge on the timeout cycle still counts as a valid measurement.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_err_next     = r_phase_err;
        w_valid_next   = 1'b0;
        w_timeout_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_g_e && w_l_e) begin
                    w_err_next   = '0;
                    w_valid_next = 1'b1;
                end else if (w_g_e) begin
                    w_cnt_next   = '0;
                    w_state_next = WAIT_L;
                end else if (w_l_e) begin
                    w_cnt_next   = '0;
                    w_state_next = WAIT_G;
                end
            end
            WAIT_L: begin
                if (w_l_e) begin
                    w_err_next   = w_cnt_inc;
                    w_valid_next = 1'b1;
                    w_state_next = IDLE;
                end else if (w_cnt_inc == CNT_W'(MAX_CNT)) begin
                    w_timeout_next = 1'b1;
                    w_state_next   = IDLE;
                end else if (w_g_e) begin
                    w_timeout_next = 1'b1;
                    w_cnt_next     = '0;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            WAIT_G: begin
                if (w_g_e) begin
                    w_err_next   = -w_cnt_inc;
                    w_valid_next = 1'b1;
                    w_state_next = IDLE;
                end else if (w_cnt_inc == CNT_W'(MAX_CNT)) begin
                    w_timeout_next = 1'b1;
                    w_state_next   = IDLE;
                end else if (w_l_e) begin
                    w_timeout_next = 1'b1;
                    w_cnt_next     = '0;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    logic [LOST_W-1:0] r_lost_cnt;
    logic              r_gps_lost;

    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            r_lost_cnt <= '0;
            r_gps_lost <= 1'b1;
        end else if (w_g_e) begin
            r_lost_cnt <= '0;
            r_gps_lost <= 1'b0;
        end else if (r_lost_cnt != LOST_W'(LOST_CNT)) begin
            r_lost_cnt <= r_lost_cnt + 1'b1;
            if (r_lost_cnt == LOST_W'(LOST_CNT - 1)) begin
                r_gps_lost <= 1'b1;
            end
        end
    end

    assign phase_err    = r_phase_err;
    assign phase_valid  = r_phase_valid;
    assign meas_timeout = r_meas_timeout;
    assign gps_lost     = r_gps_lost;

`ifdef PPS_PHASE_AVG_EN
    localparam int ACC_W = CNT_W + AVG_LOG2;

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_acc_sum;
    logic [AVG_LOG2-1:0]     r_n;
    logic                    r_gps_lost_d;
    logic [CNT_W-1:0]        r_phase_avg;
    logic                    r_avg_valid;

    assign w_acc_sum = r_acc + {{AVG_LOG2{r_phase_err[CNT_W-1]}}, r_phase_err};

    // Dropping the low AVG_LOG2 bits is the floor-rounding arithmetic shift.
    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            r_acc        <= '0;
            r_n          <= '0;
            r_gps_lost_d <= 1'b1;
            r_phase_avg  <= '0;
            r_avg_valid  <= 1'b0;
        end else begin
            r_gps_lost_d <= r_gps_lost;
            r_avg_valid  <= 1'b0;
            if (r_meas_timeout || (r_gps_lost && !r_gps_lost_d)) begin
                r_acc <= '0;
                r_n   <= '0;
            end else if (r_phase_valid) begin
                if (&r_n) begin
                    r_phase_avg <= w_acc_sum[ACC_W-1:AVG_LOG2];
                    r_avg_valid <= 1'b1;
                    r_acc       <= '0;
                    r_n         <= '0;
                end else begin
                    r_acc <= w_acc_sum;
                    r_n   <= r_n + 1'b1;
                end
            end
        end
    end

    assign phase_avg = r_phase_avg;
    assign avg_valid = r_avg_valid;
`else
    // Averaging depth only matters when the averager is built.
    if (AVG_LOG2 < 0) begin : g_avg_depth_unused
    end

    assign phase_avg = '0;
    assign avg_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pps_phase_meter.sv
// Directed bench for pps_phase_meter (CLK_HZ=1000, MAX_CNT=500, LOST_CNT=1500, AVG_LOG2=2).
module tb_pps_phase_meter;

    logic        clk;
    logic        rst_n;
    logic        gps;
    logic        loc;
    logic [31:0] phase_err;
    logic        phase_valid;
    logic        meas_timeout;
    logic        gps_lost;
    logic [31:0] phase_avg;
    logic        avg_valid;

    int vectors     = 0;
    int miscompares = 0;

    logic        avg_v_s;
    logic [31:0] avg_s;

    pps_phase_meter #(
        .CLK_HZ   (1000),
        .CNT_W    (32),
        .MAX_CNT  (500),
        .LOST_CNT (1500),
        .AVG_LOG2 (2)
    ) dut (
        .CLK_SYS      (clk),
        .CLK_RST      (rst_n),
        ._1PPS_GPS    (gps),
        ._1PPS_Local  (loc),
        .phase_err    (phase_err),
        .phase_valid  (phase_valid),
        .meas_timeout (meas_timeout),
        .gps_lost     (gps_lost),
        .phase_avg    (phase_avg),
        .avg_valid    (avg_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // d>0: GPS leads by d cycles; d<0: local leads by -d; d==0: simultaneous.
    task automatic measure(input int d, input string tag);
        int          ad;
        int          cyc;
        logic        seen_v;
        logic        seen_t;
        logic [31:0] err;
        ad     = (d < 0) ? -d : d;
        cyc    = 0;
        seen_v = 1'b0;
        seen_t = 1'b0;
        err    = '0;
        if (d >= 0) gps = 1'b1;
        if (d <= 0) loc = 1'b1;
        while (cyc < ad + 50 && !seen_v && !seen_t) begin
            @(negedge clk);
            cyc++;
            if (cyc == ad) begin
                gps = 1'b1;
                loc = 1'b1;
            end
            seen_v = phase_valid;
            seen_t = meas_timeout;
            err    = phase_err;
        end
        check({tag, "_valid"}, 32'(seen_v), 32'd1);
        check({tag, "_no_timeout"}, 32'(seen_t), 32'd0);
        check({tag, "_err"}, err, 32'(d));
        check({tag, "_latency"}, 32'(cyc), 32'(ad + 4));
        gps = 1'b0;
        loc = 1'b0;
        @(negedge clk);
        check({tag, "_single_strobe"}, 32'(phase_valid), 32'd0);
        avg_v_s = avg_valid;
        avg_s   = phase_avg;
        $display("measure %s: offset=%0d phase_err=%0d after %0d cycles", tag, d, $signed(err), cyc);
        repeat (4) @(negedge clk);
    endtask

    task automatic lone_gps_timeout(input string tag);
        int cyc;
        cyc = 0;
        gps = 1'b1;
        while (cyc < 700 && !meas_timeout && !phase_valid) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_timeout"}, 32'(meas_timeout), 32'd1);
        check({tag, "_no_valid"}, 32'(phase_valid), 32'd0);
        check({tag, "_latency"}, 32'(cyc), 32'd504);
        gps = 1'b0;
        $display("timeout %s: meas_timeout after %0d cycles", tag, cyc);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int tmo_at;
        int tmo_n;
        int val_at;
        int nval;
        int lost_at;
        logic [31:0] err_s;

        rst_n = 1'b0;
        gps   = 1'b0;
        loc   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_phase_err", phase_err, 32'd0);
        check("rst_phase_valid", 32'(phase_valid), 32'd0);
        check("rst_meas_timeout", 32'(meas_timeout), 32'd0);
        check("rst_gps_lost", 32'(gps_lost), 32'd1);
        check("rst_phase_avg", phase_avg, 32'd0);
        check("rst_avg_valid", 32'(avg_valid), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: local lags GPS by 37
        measure(37, "lag37");
        check("gps_lost_cleared", 32'(gps_lost), 32'd0);
`ifndef PPS_PHASE_AVG_EN
        check("avg_valid_off", 32'(avg_v_s), 32'd0);
        check("phase_avg_off", avg_s, 32'd0);
`endif

        // 2: local leads by 12, then simultaneous edges
        measure(-12, "lead12");
        measure(0, "same_cycle");

        // 3: lone GPS edge, then a restart by a second GPS edge
        lone_gps_timeout("lone_gps");
        tmo_at = 0;
        tmo_n  = 0;
        val_at = 0;
        err_s  = '0;
        gps    = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 100) gps = 1'b0;
            if (c == 300) gps = 1'b1;
            if (c == 350) loc = 1'b1;
            if (meas_timeout) begin
                tmo_at = c;
                tmo_n++;
            end
            if (phase_valid) begin
                val_at = c;
                err_s  = phase_err;
            end
        end
        gps = 1'b0;
        loc = 1'b0;
        check("restart_timeout_at", 32'(tmo_at), 32'd304);
        check("restart_timeout_count", 32'(tmo_n), 32'd1);
        check("restart_valid_at", 32'(val_at), 32'd354);
        check("restart_err", err_s, 32'd50);
        $display("restart: timeout at %0d, phase_err=%0d at %0d", tmo_at, $signed(err_s), val_at);
        repeat (5) @(negedge clk);

        // 4: GPS stops; gps_lost rises LOST_CNT after the last edge
        check("lost_low_before", 32'(gps_lost), 32'd0);
        lost_at = 0;
        tmo_at  = 0;
        nval    = 0;
        gps     = 1'b1;
        for (int c = 1; c <= 1600; c++) begin
            @(negedge clk);
            if (c == 20) gps = 1'b0;
            if (gps_lost && lost_at == 0) lost_at = c;
            if (meas_timeout) tmo_at = c;
            if (phase_valid) nval++;
        end
        check("lost_rise_at", 32'(lost_at), 32'd1504);
        check("lost_timeout_at", 32'(tmo_at), 32'd504);
        check("lost_no_valid", 32'(nval), 32'd0);
        $display("gps_lost: rose %0d cycles after the last GPS edge", lost_at);
        measure(20, "after_lost");
        check("lost_cleared_by_gps", 32'(gps_lost), 32'd0);

`ifdef PPS_PHASE_AVG_EN
        // 5: averaging
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        measure(4, "avg_a1");
        check("avg_a1_no_strobe", 32'(avg_v_s), 32'd0);
        measure(6, "avg_a2");
        check("avg_a2_no_strobe", 32'(avg_v_s), 32'd0);
        measure(-2, "avg_a3");
        check("avg_a3_no_strobe", 32'(avg_v_s), 32'd0);
        measure(3, "avg_a4");
        check("avg_a4_strobe", 32'(avg_v_s), 32'd1);
        check("avg_a4_value", avg_s, 32'd2);
        measure(8, "avg_b1");
        measure(8, "avg_b2");
        lone_gps_timeout("avg_clear");
        measure(1, "avg_c1");
        measure(2, "avg_c2");
        check("avg_c2_no_strobe", 32'(avg_v_s), 32'd0);
        measure(3, "avg_c3");
        check("avg_c3_no_strobe", 32'(avg_v_s), 32'd0);
        measure(-11, "avg_c4");
        check("avg_c4_strobe", 32'(avg_v_s), 32'd1);
        check("avg_c4_value", avg_s, 32'hFFFF_FFFE);
`endif

        // 6: reset while waiting for the local edge
        gps = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_phase_err", phase_err, 32'd0);
        check("midrst_phase_valid", 32'(phase_valid), 32'd0);
        check("midrst_meas_timeout", 32'(meas_timeout), 32'd0);
        check("midrst_gps_lost", 32'(gps_lost), 32'd1);
        check("midrst_phase_avg", phase_avg, 32'd0);
        gps = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nval  = 0;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            if (phase_valid || meas_timeout || avg_valid) nval++;
        end
        check("midrst_no_strobe", 32'(nval), 32'd0);
        check("midrst_gps_lost_held", 32'(gps_lost), 32'd1);
        $display("reset in WAIT_L: %0d strobes in 600 cycles afterwards", nval);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
